// File: rtl/fifo_rd_packer_if.sv
// Bundles the FIFO read port, the flush request and the packed output stream.
// The packer connects through the master modport and its environment through slave.
interface fifo_rd_packer_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int PACK_RATIO = 4
);
    localparam int CNT_W = $clog2(PACK_RATIO + 1);

    logic                             fifo_empty;
    logic                             fifo_valid;
    logic [FIFO_WIDTH-1:0]            fifo_data_out;
    logic                             fifo_rd_en;
    logic                             flush;
    logic [FIFO_WIDTH*PACK_RATIO-1:0] m_data;
    logic [CNT_W-1:0]                 m_count;
    logic                             m_valid;
    logic                             m_ready;

    modport master (
        input  fifo_empty,
        input  fifo_valid,
        input  fifo_data_out,
        input  flush,
        input  m_ready,
        output fifo_rd_en,
        output m_data,
        output m_count,
        output m_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_valid,
        output fifo_data_out,
        output flush,
        output m_ready,
        input  fifo_rd_en,
        input  m_data,
        input  m_count,
        input  m_valid
    );
endinterface

// File: rtl/fifo_rd_packer.sv
// Packs PACK_RATIO consecutive FIFO words into one wide valid/ready word, lane 0 oldest.
// Optional idle auto-flush is compiled in with PACKER_TIMEOUT_EN.
module fifo_rd_packer #(
    parameter int FIFO_WIDTH     = 16,
    parameter int PACK_RATIO     = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic              clk,
    input  logic              rst,
    fifo_rd_packer_if.master  bus
);
    localparam int CNT_W = $clog2(PACK_RATIO + 1);
    localparam int OUT_W = FIFO_WIDTH * PACK_RATIO;
    localparam logic [CNT_W:0]   SLOTS_FULL = (CNT_W + 1)'(PACK_RATIO);
    localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(PACK_RATIO);
    localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(PACK_RATIO - 1);

    if (PACK_RATIO < 2 || PACK_RATIO > 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
        $error("fifo_rd_packer: illegal parameter value");
    end

    logic [CNT_W-1:0] r_cnt;
    logic             r_inflight;
    logic             r_flush_pend;
    logic [OUT_W-1:0] r_m_data;
    logic [CNT_W-1:0] r_m_count;
    logic             r_m_valid;

    logic [CNT_W-1:0] w_cnt_next;
    logic             w_inflight_next;
    logic             w_flush_pend_next;
    logic [OUT_W-1:0] w_m_data_next;
    logic [CNT_W-1:0] w_m_count_next;
    logic             w_m_valid_next;

    logic             w_capture;
    logic             w_last;
    logic             w_cnt_full;
    logic             w_out_free;
    logic             w_flush_resolve;
    logic             w_flush_done;
    logic             w_flush_req;
    logic             w_load;
    logic             w_out_busy;
    logic [CNT_W:0]   w_used;
    logic [CNT_W:0]   w_reserved;
    logic [OUT_W-1:0] w_pack;

    assign w_capture       = bus.fifo_valid && r_inflight;
    assign w_last          = w_capture && (r_cnt == CNT_LAST);
    assign w_cnt_full      = (r_cnt == CNT_FULL);
    assign w_out_free      = !r_m_valid || bus.m_ready;
    assign w_flush_resolve = r_flush_pend && !r_inflight;

    // A word leaves the buffer when it completes now, sits complete, or a flush drains it.
    assign w_load = w_out_free &&
                    (w_last || w_cnt_full || (w_flush_resolve && (r_cnt != '0)));
    assign w_flush_done = w_flush_resolve && ((r_cnt == '0) || w_load);

    // Lanes committed to the current word; a word leaving this cycle frees them all,
    // which lets the next read issue back-to-back with the load.
    assign w_used     = {1'b0, r_cnt} + {{CNT_W{1'b0}}, r_inflight};
    assign w_reserved = w_load ? '0 : w_used;
    assign w_out_busy = r_m_valid && !bus.m_ready && (w_used == SLOTS_FULL);

    assign bus.fifo_rd_en = !bus.fifo_empty && !rst && (w_reserved < SLOTS_FULL) &&
                            !r_flush_pend && !w_out_busy;

    // The final lane is taken straight from the FIFO when a word completes.
    for (genvar gi = 0; gi < PACK_RATIO; gi++) begin : g_lane
        logic [FIFO_WIDTH-1:0] r_lane;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_lane <= '0;
            end else if (w_load) begin
                r_lane <= '0;
            end else if (w_capture && (r_cnt == CNT_W'(gi))) begin
                r_lane <= bus.fifo_data_out;
            end
        end

        if (gi == PACK_RATIO - 1) begin : g_tail
            assign w_pack[gi*FIFO_WIDTH +: FIFO_WIDTH] = w_last ? bus.fifo_data_out : r_lane;
        end else begin : g_body
            assign w_pack[gi*FIFO_WIDTH +: FIFO_WIDTH] = r_lane;
        end
    end

`ifdef PACKER_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [IDLE_W-1:0] r_idle;
    logic              w_idle;
    logic              w_timeout_flush;

    assign w_idle          = (r_cnt != '0) && !r_inflight && bus.fifo_empty && !r_flush_pend;
    assign w_timeout_flush = w_idle && (r_idle == IDLE_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idle <= '0;
        end else if (!w_idle || bus.flush || w_timeout_flush) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + 1'b1;
        end
    end

    assign w_flush_req = bus.flush || w_timeout_flush;
`else
    assign w_flush_req = bus.flush;
`endif

    always_comb begin
        w_cnt_next        = r_cnt;
        w_inflight_next   = r_inflight;
        w_flush_pend_next = r_flush_pend;
        w_m_data_next     = r_m_data;
        w_m_count_next    = r_m_count;
        w_m_valid_next    = r_m_valid;

        if (bus.fifo_rd_en) begin
            w_inflight_next = 1'b1;
        end else if (bus.fifo_valid) begin
            w_inflight_next = 1'b0;
        end

        if (w_load) begin
            w_cnt_next = '0;
        end else if (w_capture) begin
            w_cnt_next = r_cnt + 1'b1;
        end

        // A flush arriving while one is pending is absorbed by the pending one.
        if (r_flush_pend) begin
            w_flush_pend_next = !w_flush_done;
        end else begin
            w_flush_pend_next = w_flush_req;
        end

        if (w_load) begin
            w_m_data_next  = w_pack;
            w_m_count_next = w_last ? CNT_FULL : r_cnt;
            w_m_valid_next = 1'b1;
        end else if (r_m_valid && bus.m_ready) begin
            w_m_data_next  = '0;
            w_m_count_next = '0;
            w_m_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt        <= '0;
            r_inflight   <= 1'b0;
            r_flush_pend <= 1'b0;
            r_m_data     <= '0;
            r_m_count    <= '0;
            r_m_valid    <= 1'b0;
        end else begin
            r_cnt        <= w_cnt_next;
            r_inflight   <= w_inflight_next;
            r_flush_pend <= w_flush_pend_next;
            r_m_data     <= w_m_data_next;
            r_m_count    <= w_m_count_next;
            r_m_valid    <= w_m_valid_next;
        end
    end

    assign bus.m_data  = r_m_data;
    assign bus.m_count = r_m_count;
    assign bus.m_valid = r_m_valid;

    a_valid_needs_read: assert property (@(posedge clk) disable iff (rst)
        bus.fifo_valid |-> r_inflight);
endmodule
